pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It holds the fetch address and selects the next PC from sequential increment, branch target, jump target or a return-address stack (RAS). It stalls under ENABLE and supports call/return linking. It feeds instruction memory and the IF/ID register.

## Interface
- WIDTH, 32: PC and target width in bits.
- RESET_VECTOR, 0: PC value loaded on reset.
- STEP, 4: sequential increment.
- RAS_DEPTH, 4: return-address stack entries (≥2).
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = PC may update this cycle; 0 = stall (hold everything).
- SEL  in  2  next-PC source: 0 sequential, 1 branch, 2 jump, 3 return.
- BRANCH_TARGET  in  WIDTH  taken-branch address.
- JUMP_TARGET  in  WIDTH  jump address; also the fallback return address.
- LINK  in  1  push PC_OUT+STEP onto the RAS this cycle (call).
- PC_OUT  out  WIDTH  current fetch address (registered).
- PC_NEXT  out  WIDTH  address to be loaded at the next enabled edge (combinational).
- RAS_EMPTY  out  1  RAS holds 0 entries.
- RAS_FULL  out  1  RAS holds RAS_DEPTH entries.
- RAS_UNDERFLOW  out  1  sticky; set on return with empty RAS.

## Operation
- Next-PC selection:
  - SEL=0: PC_OUT+STEP.
  - SEL=1: BRANCH_TARGET.
  - SEL=2: JUMP_TARGET.
  - SEL=3: RAS top if not empty, else JUMP_TARGET.
- Arithmetic is modulo 2^WIDTH. PC_OUT+STEP wraps silently.
- RAS is a circular buffer with a top pointer and an occupancy count (0..RAS_DEPTH).
- Push (LINK=1, SEL≠3):
  - Writes PC_OUT+STEP at top+1 and advances top.
  - Count saturates at RAS_DEPTH.
  - When full, the push overwrites the oldest entry and RAS_FULL stays 1.
- Pop (SEL=3, not empty): retreats top, decrements count.
- Pop with empty RAS: no pointer change, PC uses JUMP_TARGET, RAS_UNDERFLOW set to 1.
- Simultaneous pop+push (SEL=3, LINK=1):
  - Not empty: the top entry is replaced by PC_OUT+STEP, count unchanged, PC takes the old top.
  - Empty: push only (count becomes 1), PC uses JUMP_TARGET, RAS_UNDERFLOW set.
- ENABLE=0: PC_OUT, RAS contents, pointer, count and flags all hold. SEL/LINK are ignored. PC_NEXT still reflects the current inputs.
- LINK with SEL=1 is legal (branch-and-link) and pushes.
- Reset:
  - PC_OUT=RESET_VECTOR, count=0, top=0, RAS_EMPTY=1, RAS_FULL=0, RAS_UNDERFLOW=0.
  - RAS entry contents are don't-care.
  - Reset asserted mid-operation wins immediately, without waiting for a clock edge.

## Timing
- PC_OUT and all RAS state update only on a CLK rising edge with ENABLE=1 and RESET=0.
- Latency: a SEL/target presented in cycle N appears on PC_OUT after the edge ending cycle N.
- PC_NEXT: zero-latency combinational function of SEL, targets, PC_OUT and the RAS top.
- RAS_EMPTY and RAS_FULL: registered-derived from count; valid the cycle after a push/pop edge.
- RAS_UNDERFLOW: rises after the offending edge. Cleared only by RESET.
- RESET release: the first enabled edge after deassertion loads PC_NEXT normally.
- No combinational path from PC_NEXT back into selection; no loops.

## Test plan
- Reset/sequential: assert RESET with RESET_VECTOR=0x00400000, release, ENABLE=1, SEL=0 for 3 edges -> PC_OUT 0x00400000, 0x00400004, 0x00400008, 0x0040000C. Assert RESET asynchronously mid-cycle -> PC_OUT=0x00400000 before the next edge.
- Stall: at PC_OUT=0x10, ENABLE=0 for 2 edges with SEL=2, JUMP_TARGET=0x80, LINK=1 -> PC_OUT stays 0x10, RAS_EMPTY stays 1. Set ENABLE=1 -> PC_OUT=0x80, RAS top=0x14.
- Call/return nesting: from 0x100 jump-link to 0x200, then from 0x200 jump-link to 0x300, then SEL=3 twice -> PC_OUT 0x204 then 0x104, RAS_EMPTY=1.
- Overflow: RAS_DEPTH=4, five linked jumps from PCs 0x0,0x10,0x20,0x30,0x40 -> RAS_FULL=1. Four pops -> 0x44,0x34,0x24,0x14 (0x4 lost), RAS_EMPTY=1.
- Underflow: empty RAS, SEL=3, JUMP_TARGET=0xABC -> PC_OUT=0xABC, RAS_UNDERFLOW=1, held until RESET.
- Wrap/replace: PC_OUT=0xFFFFFFFC, SEL=0 -> PC_OUT=0x0. RAS holds [0x50], SEL=3, LINK=1 at PC_OUT=0x60 -> PC_OUT=0x50, RAS top=0x64, count=1.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection and a circular return-address stack.
// PC_NEXT is the combinational next address; every other output comes from registered state.
module pc_unit #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       SEL,
    input  logic [WIDTH-1:0] BRANCH_TARGET,
    input  logic [WIDTH-1:0] JUMP_TARGET,
    input  logic             LINK,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] PC_NEXT,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             RAS_UNDERFLOW
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_RET    = 2'd3;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec, wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             underflow_d;
    logic             ras_we;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty_c;
    logic             ras_full_c;

    // Next-PC mux and RAS push/pop decisions
    always_comb begin
        pc_seq      = PC_OUT + WIDTH'(STEP);
        ras_top     = ras_q[top_q];
        ras_empty_c = (cnt_q == '0);
        ras_full_c  = (cnt_q == CNT_W'(RAS_DEPTH));
        top_inc     = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
        top_dec     = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

        top_d       = top_q;
        cnt_d       = cnt_q;
        underflow_d = RAS_UNDERFLOW;
        ras_we      = 1'b0;
        wr_ptr      = top_inc;

        unique case (SEL)
            SEL_SEQ:    PC_NEXT = pc_seq;
            SEL_BRANCH: PC_NEXT = BRANCH_TARGET;
            SEL_JUMP:   PC_NEXT = JUMP_TARGET;
            default:    PC_NEXT = ras_empty_c ? JUMP_TARGET : ras_top;
        endcase

        if (SEL == SEL_RET) begin
            if (!ras_empty_c) begin
                if (LINK) begin
                    // return-and-call: overwrite the popped slot in place
                    ras_we = 1'b1;
                    wr_ptr = top_q;
                end else begin
                    top_d = top_dec;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                underflow_d = 1'b1;
                if (LINK) begin
                    ras_we = 1'b1;
                    top_d  = top_inc;
                    cnt_d  = CNT_W'(1);
                end
            end
        end else if (LINK) begin
            // when full, the push lands on the oldest entry
            ras_we = 1'b1;
            top_d  = top_inc;
            cnt_d  = ras_full_c ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC_OUT        <= RESET_VECTOR;
            top_q         <= '0;
            cnt_q         <= '0;
            RAS_UNDERFLOW <= 1'b0;
        end else if (ENABLE) begin
            PC_OUT        <= PC_NEXT;
            top_q         <= top_d;
            cnt_q         <= cnt_d;
            RAS_UNDERFLOW <= underflow_d;
        end
    end

    // Stack storage needs no reset; occupancy tracks validity
    always_ff @(posedge CLK) begin
        if (ENABLE && !RESET && ras_we) begin
            ras_q[wr_ptr] <= pc_seq;
        end
    end

    assign RAS_EMPTY = ras_empty_c;
    assign RAS_FULL  = ras_full_c;

endmodule
